// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, NREAD read ports, PC alias input and pending scoreboard.
// The decode stage drives it as master; the register file is the slave.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int NREAD = 3
);
    localparam int AW = $clog2(NREGS);

    logic                   we3;
    logic [AW-1:0]          a3;
    logic [WIDTH-1:0]       wd3;
    logic                   we4;
    logic [AW-1:0]          a4;
    logic [WIDTH-1:0]       wd4;
    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       rbusy;
    logic [WIDTH-1:0]       r15;
    logic                   pend_set;
    logic [AW-1:0]          pend_a3;
    logic                   pend_long;
    logic [AW-1:0]          pend_a4;
    logic                   any_busy;

    modport master (
        output we3, a3, wd3, we4, a4, wd4, ra, r15,
        output pend_set, pend_a3, pend_long, pend_a4,
        input  rd, rbusy, any_busy
    );

    modport slave (
        input  we3, a3, wd3, we4, a4, wd4, ra, r15,
        input  pend_set, pend_a3, pend_long, pend_a4,
        output rd, rbusy, any_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass, PC alias at the top index
// and a per-register pending scoreboard for multi-cycle producers.
module regfile_mp #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int NREAD = 3
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam int PC = NREGS - 1;

    logic [WIDTH-1:0] rf [NREGS-1];
    logic [NREGS-2:0] pend;
    logic [NREGS-2:0] pend_nxt;

    // Clear on write first, then set, so an issue in the same cycle as a write keeps the bit.
    always_comb begin
        pend_nxt = pend;
        for (int k = 0; k < NREGS - 1; k++) begin
            if ((bus.we3 && bus.a3 == AW'(k)) || (bus.we4 && bus.a4 == AW'(k)))
                pend_nxt[k] = 1'b0;
            if (bus.pend_set && (bus.pend_a3 == AW'(k) ||
                                 (bus.pend_long && bus.pend_a4 == AW'(k))))
                pend_nxt[k] = 1'b1;
        end
    end

    // Port 4 is assigned last so it wins an address collision; index PC has no entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS - 1; k++) rf[k] <= '0;
            pend <= '0;
        end else begin
            for (int k = 0; k < NREGS - 1; k++) begin
                if (bus.we3 && bus.a3 == AW'(k)) rf[k] <= bus.wd3;
                if (bus.we4 && bus.a4 == AW'(k)) rf[k] <= bus.wd4;
            end
            pend <= pend_nxt;
        end
    end

    assign bus.any_busy = |pend;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    r;
        logic [WIDTH-1:0] stored;
        logic [WIDTH-1:0] val;
        logic             pnd;
        logic             busy;

        assign r = bus.ra[i*AW +: AW];

        always_comb begin
            stored = '0;
            pnd    = 1'b0;
            for (int k = 0; k < NREGS - 1; k++) begin
                if (r == AW'(k)) begin
                    stored = rf[k];
                    pnd    = pend[k];
                end
            end
            if (r == AW'(PC))                    val = bus.r15;
            else if (bus.we4 && bus.a4 == r)     val = bus.wd4;
            else if (bus.we3 && bus.a3 == r)     val = bus.wd3;
            else                                 val = stored;
            busy = pnd && !(bus.we3 && bus.a3 == r) && !(bus.we4 && bus.a4 == r);
        end

        assign bus.rd[i*WIDTH +: WIDTH] = val;
        assign bus.rbusy[i]             = busy;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, collision, PC alias, pending scoreboard.
module tb_regfile_mp;
    localparam int WIDTH = 32;
    localparam int NREGS = 16;
    localparam int NREAD = 3;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    regfile_mp_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) bus ();

    regfile_mp #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here, outputs sampled #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we3 = 0; bus.a3 = '0; bus.wd3 = '0;
        bus.we4 = 0; bus.a4 = '0; bus.wd4 = '0;
        bus.pend_set = 0; bus.pend_a3 = '0; bus.pend_long = 0; bus.pend_a4 = '0;
    endtask

    task automatic set_ra(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
        bus.ra = {p2, p1, p0};
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        logic [31:0] got;
        idle();
        bus.r15 = 32'h0000_1008;
        set_ra(0, 0, 0);
        reset = 1;
        step();
        step();
        reset = 0;
        for (int idx = 0; idx < NREGS; idx++) begin
            set_ra(idx[3:0], idx[3:0], idx[3:0]);
            #1;
            exp = (idx == NREGS - 1) ? 32'h0000_1008 : 32'h0;
            for (int p = 0; p < NREAD; p++) begin
                got = bus.rd[p*WIDTH +: WIDTH];
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL reset_rd idx=%0d port=%0d got=%h exp=%h", idx, p, got, exp);
                end
            end
            checks++;
            if (bus.rbusy !== 3'b000) begin
                errors++;
                $display("FAIL reset_rbusy idx=%0d got=%b exp=000", idx, bus.rbusy);
            end
        end
        checks++;
        if (bus.any_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_any_busy got=%b exp=0", bus.any_busy);
        end
    endtask

    task automatic test_bypass();
        step();
        bus.we3 = 1; bus.a3 = 4'd2; bus.wd3 = 32'hDEAD_BEEF;
        set_ra(2, 3, 15);
        #1;
        checks++;
        if (bus.rd[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle got=%h exp=deadbeef", bus.rd[31:0]);
        end
        checks++;
        if (bus.rd[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL bypass_other_reg got=%h exp=00000000", bus.rd[63:32]);
        end
        step();
        bus.we3 = 0;
        #1;
        checks++;
        if (bus.rd[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_stored got=%h exp=deadbeef", bus.rd[31:0]);
        end
    endtask

    task automatic test_collision();
        step();
        bus.we3 = 1; bus.a3 = 4'd5; bus.wd3 = 32'h1111;
        bus.we4 = 1; bus.a4 = 4'd5; bus.wd4 = 32'h2222;
        set_ra(5, 5, 2);
        #1;
        checks++;
        if (bus.rd[63:0] !== {32'h2222, 32'h2222}) begin
            errors++;
            $display("FAIL collision_bypass got=%h exp=%h", bus.rd[63:0], {32'h2222, 32'h2222});
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rd[31:0] !== 32'h2222) begin
            errors++;
            $display("FAIL collision_stored got=%h exp=00002222", bus.rd[31:0]);
        end
        checks++;
        if (bus.rd[95:64] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL collision_r2_kept got=%h exp=deadbeef", bus.rd[95:64]);
        end
    endtask

    task automatic test_pc_alias();
        step();
        bus.we3 = 1; bus.a3 = 4'd15; bus.wd3 = 32'h5555;
        set_ra(15, 14, 0);
        #1;
        checks++;
        if (bus.rd[31:0] !== 32'h0000_1008) begin
            errors++;
            $display("FAIL pc_write_bypass got=%h exp=00001008", bus.rd[31:0]);
        end
        step();
        bus.we3 = 0;
        bus.r15 = 32'h0000_2008;
        #1;
        checks++;
        if (bus.rd[31:0] !== 32'h0000_2008) begin
            errors++;
            $display("FAIL pc_after_write got=%h exp=00002008", bus.rd[31:0]);
        end
        checks++;
        if (bus.rd[95:32] !== 64'h0) begin
            errors++;
            $display("FAIL pc_write_leak got=%h exp=0", bus.rd[95:32]);
        end
        bus.r15 = 32'h0000_1008;
    endtask

    task automatic test_pending();
        step();
        bus.pend_set = 1; bus.pend_a3 = 4'd4; bus.pend_long = 1; bus.pend_a4 = 4'd6;
        set_ra(4, 6, 5);
        #1;
        checks++;
        if (bus.rbusy !== 3'b000 || bus.any_busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_issue_cycle rbusy=%b any=%b exp 000/0", bus.rbusy, bus.any_busy);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rbusy !== 3'b011 || bus.any_busy !== 1'b1) begin
            errors++;
            $display("FAIL pend_marked rbusy=%b any=%b exp 011/1", bus.rbusy, bus.any_busy);
        end
        step();
        bus.we3 = 1; bus.a3 = 4'd4; bus.wd3 = 32'hA4;
        bus.we4 = 1; bus.a4 = 4'd6; bus.wd4 = 32'hA6;
        #1;
        checks++;
        if (bus.rbusy !== 3'b000 || bus.any_busy !== 1'b1) begin
            errors++;
            $display("FAIL pend_write_cycle rbusy=%b any=%b exp 000/1", bus.rbusy, bus.any_busy);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.any_busy !== 1'b0 || bus.rd[63:0] !== {32'hA6, 32'hA4}) begin
            errors++;
            $display("FAIL pend_cleared any=%b rd=%h exp 0/%h", bus.any_busy, bus.rd[63:0], {32'hA6, 32'hA4});
        end
        // pend_long low must leave pend_a4 alone
        bus.pend_set = 1; bus.pend_a3 = 4'd8; bus.pend_long = 0; bus.pend_a4 = 4'd9;
        set_ra(8, 9, 15);
        step();
        idle();
        #1;
        checks++;
        if (bus.rbusy !== 3'b001) begin
            errors++;
            $display("FAIL pend_short rbusy=%b exp=001", bus.rbusy);
        end
        bus.we4 = 1; bus.a4 = 4'd8; bus.wd4 = 32'h88;
        step();
        idle();
        #1;
        checks++;
        if (bus.any_busy !== 1'b0 || bus.rd[31:0] !== 32'h88) begin
            errors++;
            $display("FAIL pend_short_clear any=%b rd=%h exp 0/00000088", bus.any_busy, bus.rd[31:0]);
        end
    endtask

    task automatic test_set_beats_clear();
        bus.we3 = 1; bus.a3 = 4'd7; bus.wd3 = 32'h77;
        bus.pend_set = 1; bus.pend_a3 = 4'd7;
        set_ra(7, 0, 1);
        step();
        idle();
        #1;
        checks++;
        if (bus.rbusy !== 3'b001 || bus.any_busy !== 1'b1 || bus.rd[31:0] !== 32'h77) begin
            errors++;
            $display("FAIL set_beats_clear rbusy=%b any=%b rd=%h exp 001/1/00000077",
                     bus.rbusy, bus.any_busy, bus.rd[31:0]);
        end
    endtask

    task automatic test_reset_override();
        bus.pend_set = 1; bus.pend_a3 = 4'd3;
        set_ra(3, 7, 9);
        step();
        idle();
        reset = 1;
        bus.we3 = 1; bus.a3 = 4'd3; bus.wd3 = 32'h33;
        bus.pend_set = 1; bus.pend_a3 = 4'd9;
        #1;
        checks++;
        if (bus.rbusy[0] !== 1'b0 || bus.rd[31:0] !== 32'h33) begin
            errors++;
            $display("FAIL reset_cycle_bypass rbusy0=%b rd=%h exp 0/00000033", bus.rbusy[0], bus.rd[31:0]);
        end
        step();
        reset = 0;
        idle();
        #1;
        checks++;
        if (bus.rd[95:0] !== 96'h0 || bus.rbusy !== 3'b000 || bus.any_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_override rd=%h rbusy=%b any=%b exp 0/000/0",
                     bus.rd[95:0], bus.rbusy, bus.any_busy);
        end
    endtask

    initial begin
        reset = 1;
        bus.ra = '0;
        bus.r15 = '0;
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_pc_alias();
        test_pending();
        test_set_beats_clear();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
